// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssd_pkg;

   // Segment vector {a,b,c,d,e,f,g}, bit 6 = a.
   typedef logic [6:0] seg_t;

   // Segments off, active-high sense (before any polarity inversion).
   localparam seg_t SEG_OFF_HI = 7'b0000000;

   // Hex nibble -> active-high segment pattern; entry N is HEX_SEG_TABLE[N].
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'b1000111,   // F
      7'b1001111,   // E
      7'b0111101,   // d
      7'b1001110,   // C
      7'b0011111,   // b
      7'b1110111,   // A
      7'b1110011,   // 9
      7'b1111111,   // 8
      7'b1110000,   // 7
      7'b1011111,   // 6
      7'b1011011,   // 5
      7'b0110011,   // 4
      7'b1111001,   // 3
      7'b1101101,   // 2
      7'b0110000,   // 1
      7'b1111110    // 0
   };

endpackage

// File: rtl/ssd_hex_decode.sv
// Hex nibble to active-high seven-segment pattern lookup.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: nib (4-bit hex digit in), seg (7-bit segment pattern out, bit 6 = a).
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);

   assign seg = HEX_SEG_TABLE[nib];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with dead time, leading-zero blanking and per-digit enables.
// Latency: outputs registered, 1 cycle after the cnt/idx/shadow state they reflect.
// Backpressure: none; scan is free-running, load is a fire-and-forget strobe.
// Ports: clk/rst (sync, active-high); load strobes digits_in/dig_en into shadow registers;
//        lz_blank level enables leading-zero suppression; seg/dig_sel drive the display pins;
//        scan_tick pulses for one cycle each time the digit index advances.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int REFRESH_DIV    = 100000,
   parameter int BLANK_CYCLES   = 4,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int SEL_ACTIVE_LOW = 0
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dig_en,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    scan_tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam seg_t                  SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF_HI : SEG_OFF_HI;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

   // Reject parameter sets that cannot produce a usable scan.
   if (NUM_DIGITS < 1) begin : g_bad_num_digits
      $error("ssd_scan_driver: NUM_DIGITS must be >= 1");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("ssd_scan_driver: REFRESH_DIV must be >= 2");
   end
   if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
      $error("ssd_scan_driver: BLANK_CYCLES must be in [0, REFRESH_DIV)");
   end

   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]      dig_q, dig_d;
   logic [NUM_DIGITS-1:0]           en_q, en_d;
   seg_t                            seg_q, seg_d;
   logic [NUM_DIGITS-1:0]           sel_q, sel_d;
   logic                            tick_q, tick_d;

   logic [3:0]                      cur_nib;
   seg_t                            cur_seg;
   logic [NUM_DIGITS-1:0]           upper_zero;
   logic [NUM_DIGITS-1:0]           sel_onehot;
   logic                            dead;
   logic                            blank_digit;
   seg_t                            seg_hi;
   logic [NUM_DIGITS-1:0]           sel_hi;

   assign cur_nib = dig_q[idx_q];

   ssd_hex_decode u_hex_decode (
      .nib (cur_nib),
      .seg (cur_seg)
   );

   // upper_zero[i]: every shadow nibble at position i and above is zero,
   // i.e. digit i is a leading zero regardless of the enables.
   always_comb begin
      upper_zero = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         upper_zero[i] = 1'b1;
         for (int j = i; j < NUM_DIGITS; j++) begin
            if (dig_q[j] != 4'h0) begin
               upper_zero[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      // Slot counter and digit index.
      cnt_d  = cnt_q + 1'b1;
      idx_d  = idx_q;
      tick_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // Shadow registers; scan position is untouched by a load.
      dig_d = load ? digits_in : dig_q;
      en_d  = load ? dig_en    : en_q;

      // Digit 0 is never zero-suppressed so an all-zero value still shows "0".
      dead        = (cnt_q < CNT_BLANK);
      blank_digit = !en_q[idx_q] ||
                    (lz_blank && (idx_q != '0) && upper_zero[idx_q]);

      sel_onehot        = '0;
      sel_onehot[idx_q] = 1'b1;

      if (dead) begin
         seg_hi = SEG_OFF_HI;
         sel_hi = '0;
      end else begin
         seg_hi = blank_digit ? SEG_OFF_HI : cur_seg;
         sel_hi = sel_onehot;
      end

      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
      sel_d = (SEL_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         dig_q  <= '0;
         en_q   <= '0;
         seg_q  <= SEG_OFF;
         sel_q  <= SEL_OFF;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         dig_q  <= dig_d;
         en_q   <= en_d;
         seg_q  <= seg_d;
         sel_q  <= sel_d;
         tick_q <= tick_d;
      end
   end

   assign seg       = seg_q;
   assign dig_sel   = sel_q;
   assign scan_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: 4 digits, 8-cycle slots, 2 dead-time cycles.
// Latency: n/a.
// Backpressure: n/a.
module tb_ssd_scan_driver;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dig_en;
   logic        lz_blank;

   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic        scan_tick;
   logic [6:0]  seg_lo;
   logic [3:0]  sel_lo;
   logic        tick_lo;

   int total;
   int bad;

   ssd_scan_driver #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (8),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (0),
      .SEL_ACTIVE_LOW (0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .digits_in (digits_in),
      .dig_en    (dig_en),
      .lz_blank  (lz_blank),
      .seg       (seg),
      .dig_sel   (dig_sel),
      .scan_tick (scan_tick)
   );

   ssd_scan_driver #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (8),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1),
      .SEL_ACTIVE_LOW (1)
   ) dut_lo (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .digits_in (digits_in),
      .dig_en    (dig_en),
      .lz_blank  (lz_blank),
      .seg       (seg_lo),
      .dig_sel   (sel_lo),
      .scan_tick (tick_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One output slot: optional load applied in the slot's first cycle,
   // expected digit index and segment pattern for the active part.
   typedef struct {
      int         idx;
      bit         ld;
      logic [15:0] dat;
      logic [3:0] en;
      bit         lz;
      logic [6:0] seg;
   } slot_t;

   slot_t tbl [23];

   localparam logic [6:0] S_OFF = 7'b0000000;
   localparam logic [6:0] S_0   = 7'b1111110;
   localparam logic [6:0] S_1   = 7'b0110000;
   localparam logic [6:0] S_3   = 7'b1111001;
   localparam logic [6:0] S_5   = 7'b1011011;
   localparam logic [6:0] S_7   = 7'b1110000;
   localparam logic [6:0] S_A   = 7'b1110111;
   localparam logic [6:0] S_F   = 7'b1000111;

   function automatic slot_t mk(int idx, bit ld, logic [15:0] dat, logic [3:0] en, bit lz,
                                logic [6:0] sg);
      slot_t s;
      s.idx = idx; s.ld = ld; s.dat = dat; s.en = en; s.lz = lz; s.seg = sg;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Checks both instances; the active-low one must be the bitwise inverse.
   task automatic chk_out(input string name, input logic [6:0] es, input logic [3:0] el,
                          input logic et);
      chk({name, " hi"}, {20'd0, seg, dig_sel, scan_tick}, {20'd0, es, el, et});
      chk({name, " lo"}, {20'd0, seg_lo, sel_lo, tick_lo}, {20'd0, ~es, ~el, et});
   endtask

   // Entered at the negedge of the cycle where cnt=0 for slot s.idx.
   task automatic run_slot(input int r);
      slot_t       s;
      logic [6:0]  es;
      logic [3:0]  el;
      s = tbl[r];
      lz_blank = s.lz;
      if (s.ld) begin
         load      = 1'b1;
         digits_in = s.dat;
         dig_en    = s.en;
      end
      for (int c = 1; c <= 8; c++) begin
         step();
         load = 1'b0;
         if (c <= 2) begin
            es = S_OFF;
            el = 4'b0000;
         end else begin
            es = s.seg;
            el = 4'b0001 << s.idx;
         end
         chk_out($sformatf("slot%0d c%0d", r, c), es, el, (c == 8));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      tbl[0]  = mk(0, 0, 16'h0000, 4'h0, 0, S_OFF);
      tbl[1]  = mk(1, 1, 16'h3A70, 4'hF, 0, S_7);
      tbl[2]  = mk(2, 0, 16'h0000, 4'h0, 0, S_A);
      tbl[3]  = mk(3, 0, 16'h0000, 4'h0, 0, S_3);
      tbl[4]  = mk(0, 0, 16'h0000, 4'h0, 0, S_0);
      tbl[5]  = mk(1, 1, 16'h0050, 4'hF, 1, S_5);
      tbl[6]  = mk(2, 0, 16'h0000, 4'h0, 1, S_OFF);
      tbl[7]  = mk(3, 0, 16'h0000, 4'h0, 1, S_OFF);
      tbl[8]  = mk(0, 0, 16'h0000, 4'h0, 1, S_0);
      tbl[9]  = mk(1, 1, 16'h0000, 4'hF, 1, S_OFF);
      tbl[10] = mk(2, 0, 16'h0000, 4'h0, 1, S_OFF);
      tbl[11] = mk(3, 0, 16'h0000, 4'h0, 1, S_OFF);
      tbl[12] = mk(0, 0, 16'h0000, 4'h0, 1, S_0);
      tbl[13] = mk(1, 1, 16'hFFFF, 4'b0101, 0, S_OFF);
      tbl[14] = mk(2, 0, 16'h0000, 4'h0, 0, S_F);
      tbl[15] = mk(3, 0, 16'h0000, 4'h0, 0, S_OFF);
      tbl[16] = mk(0, 0, 16'h0000, 4'h0, 0, S_F);
      tbl[17] = mk(1, 0, 16'h0000, 4'h0, 0, S_OFF);
      // After the mid-slot reset: shadow cleared, then digit "1" at position 0.
      tbl[18] = mk(0, 0, 16'h0000, 4'h0, 0, S_OFF);
      tbl[19] = mk(1, 1, 16'h0001, 4'hF, 0, S_0);
      tbl[20] = mk(2, 0, 16'h0000, 4'h0, 0, S_0);
      tbl[21] = mk(3, 0, 16'h0000, 4'h0, 0, S_0);
      tbl[22] = mk(0, 0, 16'h0000, 4'h0, 0, S_1);

      rst       = 1'b1;
      load      = 1'b0;
      digits_in = 16'h0000;
      dig_en    = 4'h0;
      lz_blank  = 1'b0;

      for (int k = 0; k < 3; k++) begin
         step();
         chk_out($sformatf("reset%0d", k), S_OFF, 4'b0000, 1'b0);
      end
      rst = 1'b0;

      for (int r = 0; r <= 17; r++) begin
         run_slot(r);
      end

      // Slot for digit 2 holding F: load mid-slot, then reset inside the slot.
      step(); chk_out("mid dead1", S_OFF, 4'b0000, 1'b0);
      step(); chk_out("mid dead2", S_OFF, 4'b0000, 1'b0);
      step(); chk_out("mid F a",   S_F,   4'b0100, 1'b0);
      step(); chk_out("mid F b",   S_F,   4'b0100, 1'b0);
      load      = 1'b1;
      digits_in = 16'h0500;
      dig_en    = 4'hF;
      lz_blank  = 1'b0;
      step(); load = 1'b0;
      chk_out("mid old",   S_F,   4'b0100, 1'b0);
      step(); chk_out("mid new",   S_5,   4'b0100, 1'b0);
      rst = 1'b1;
      step(); chk_out("mid rst",   S_OFF, 4'b0000, 1'b0);
      rst = 1'b0;

      for (int r = 18; r <= 22; r++) begin
         run_slot(r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
